// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes valid/ready bitstream words MSB-first onto ccff_head.
// Optional readback of ccff_tail is compiled in with `define CCFF_READBACK_EN.
module ccff_chain_loader #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              prog_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WB_W-1:0]   wb_q, wb_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              ready_q, ready_d;
    logic              head_q, head_d;
    logic              shen_q, shen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_s;
    logic              take_s;
    logic [CNT_W-1:0]  take_rem_s;

    function automatic logic [WB_W-1:0] word_bits(input logic [CNT_W-1:0] rem);
        if (rem >= CNT_W'(WORD_W)) begin
            return WB_W'(WORD_W);
        end else begin
            return WB_W'(rem);
        end
    endfunction

    assign hs_s = s_valid && ready_q;

    // Next-state logic; rem_q/wb_q count bits still to shift including the one on ccff_head.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        wb_d       = wb_q;
        sr_d       = sr_q;
        ready_d    = 1'b0;
        head_d     = head_q;
        shen_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        take_s     = 1'b0;
        take_rem_s = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (chain_len != {CNT_W{1'b0}}) begin
                        state_d = LOAD;
                        rem_d   = chain_len;
                        busy_d  = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (hs_s) begin
                    take_s = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                    rem_d   = {CNT_W{1'b0}};
                    wb_d    = {WB_W{1'b0}};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (wb_q == WB_W'(1)) begin
                    rem_d      = rem_q - CNT_W'(1);
                    take_rem_s = rem_q - CNT_W'(1);
                    if (hs_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_d = LOAD;
                        wb_d    = {WB_W{1'b0}};
                        ready_d = 1'b1;
                    end
                end else begin
                    head_d  = sr_q[WORD_W-1];
                    sr_d    = {sr_q[WORD_W-2:0], 1'b0};
                    rem_d   = rem_q - CNT_W'(1);
                    wb_d    = wb_q - WB_W'(1);
                    shen_d  = 1'b1;
                    ready_d = (wb_d == WB_W'(1)) && (rem_d > CNT_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A partial last word only ever shifts its top take_rem_s bits.
        if (take_s) begin
            state_d = SHIFT;
            rem_d   = take_rem_s;
            head_d  = s_data[WORD_W-1];
            sr_d    = {s_data[WORD_W-2:0], 1'b0};
            wb_d    = word_bits(take_rem_s);
            shen_d  = 1'b1;
            ready_d = (wb_d == WB_W'(1)) && (take_rem_s > CNT_W'(1));
        end else begin
            take_rem_s = take_rem_s;
        end
    end

    // State and registered outputs; reset drops ccff_shift_en immediately.
    always_ff @(posedge prog_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= {CNT_W{1'b0}};
            wb_q    <= {WB_W{1'b0}};
            sr_q    <= {WORD_W{1'b0}};
            ready_q <= 1'b0;
            head_q  <= 1'b0;
            shen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wb_q    <= wb_d;
            sr_q    <= sr_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            shen_q  <= shen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready       = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shen_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic [WB_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_word_s;

    // Tail samples are placed left-aligned directly, so a short final word is zero-padded.
    always_comb begin
        rb_acc_d   = rb_acc_q;
        rb_cnt_d   = rb_cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        rb_word_s  = rb_acc_q | ({ccff_tail, {(WORD_W-1){1'b0}}} >> rb_cnt_q);
        if (shen_q) begin
            if ((rb_cnt_q == WB_W'(WORD_W - 1)) || (rem_q == CNT_W'(1))) begin
                rb_data_d  = rb_word_s;
                rb_valid_d = 1'b1;
                rb_acc_d   = {WORD_W{1'b0}};
                rb_cnt_d   = {WB_W{1'b0}};
            end else begin
                rb_acc_d = rb_word_s;
                rb_cnt_d = rb_cnt_q + WB_W'(1);
            end
        end else begin
            rb_valid_d = 1'b0;
        end
    end

    // Readback registers.
    always_ff @(posedge prog_clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_acc_q   <= {WORD_W{1'b0}};
            rb_data_q  <= {WORD_W{1'b0}};
            rb_cnt_q   <= {WB_W{1'b0}};
            rb_valid_q <= 1'b0;
        end else begin
            rb_acc_q   <= rb_acc_d;
            rb_data_q  <= rb_data_d;
            rb_cnt_q   <= rb_cnt_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail_s;
    assign unused_tail_s = ccff_tail;
`endif

endmodule
